// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, program bound and FSM encoding for instruction_fetch.
//   ADDR_W    : instruction address width
//   INSTR_W   : instruction word width
//   PROG_LAST : highest legal program address; pc never moves past it
//   fetch_state_e : FETCH (issuing), STALL (decode holding), DRAIN (no more issue)
package fetch_pkg;

  localparam int ADDR_W  = 4;
  localparam int INSTR_W = 16;
  localparam logic [ADDR_W-1:0] PROG_LAST = 4'd8;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    STALL = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  // True once an address has reached (or passed) the last program word.
  function automatic logic pc_at_last(input logic [ADDR_W-1:0] pc);
    return (pc >= PROG_LAST);
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: bundles the instruction-memory bus and the decode-side
// handshake of the fetch unit.
//   master modport : fetch unit (drives address and decode outputs)
//   slave modport  : memory + decode environment
interface instruction_fetch_if;
  import fetch_pkg::*;

  logic [ADDR_W-1:0]  mem_address;
  logic [INSTR_W-1:0] mem_instruction;
  logic               stall;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_target;
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               halted;
  logic               fetch_fault;

  modport master (
    output mem_address, instr_out, instr_pc, instr_valid, halted, fetch_fault,
    input  mem_instruction, stall, redirect, redirect_target
  );

  modport slave (
    input  mem_address, instr_out, instr_pc, instr_valid, halted, fetch_fault,
    output mem_instruction, stall, redirect, redirect_target
  );

endinterface

// File: rtl/instruction_fetch_pc_counter.sv
// pc_counter: program counter register for the fetch unit.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   load, load_value : load a new pc (redirect or replay); has priority
//   inc            : advance by one, saturating at PROG_LAST
//   pc             : current program counter (drives the memory address)
module pc_counter
  import fetch_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_value,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_r;

  // pc register: load beats increment; increment stops at the last program word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_r <= {ADDR_W{1'b0}};
    end else if (load) begin
      pc_r <= load_value;
    end else if (inc && !pc_at_last(pc_r)) begin
      pc_r <= pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: drives the instruction-memory read address, tracks the word
// in flight through the memory's one-edge registered read, and presents
// instructions to decode with a valid/stall handshake plus branch redirects.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   bus (master)   : mem_address/mem_instruction memory bus, stall/redirect/
//                    redirect_target from decode, instr_out/instr_pc/instr_valid,
//                    halted and fetch_fault status
// Optional feature: define IF_FAULT_EN to make an out-of-range redirect set the
// sticky fetch_fault flag; otherwise fetch_fault is tied low. In both builds
// such a redirect flushes and drains without moving pc.
module instruction_fetch
  import fetch_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  instruction_fetch_if.master  bus
);

  fetch_state_e       state_r, state_s;
  logic [ADDR_W-1:0]  infl_pc_r, infl_pc_s;
  logic               infl_v_r, infl_v_s;
  logic [INSTR_W-1:0] out_instr_r, out_instr_s;
  logic [ADDR_W-1:0]  out_pc_r, out_pc_s;
  logic               out_valid_r, out_valid_s;
  logic               fault_r, fault_s;

  logic               pc_load_s;
  logic [ADDR_W-1:0]  pc_load_value_s;
  logic               pc_inc_s;
  logic [ADDR_W-1:0]  pc_s;
  logic               stall_eff_s;

  pc_counter u_pc (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (pc_load_s),
    .load_value (pc_load_value_s),
    .inc        (pc_inc_s),
    .pc         (pc_s)
  );

  // A stall only matters when decode is actually holding a valid word.
  assign stall_eff_s = bus.stall & out_valid_r;

  // Next-state and datapath control; every register holds unless told otherwise.
  always_comb begin
    state_s         = state_r;
    infl_pc_s       = infl_pc_r;
    infl_v_s        = infl_v_r;
    out_instr_s     = out_instr_r;
    out_pc_s        = out_pc_r;
    out_valid_s     = out_valid_r;
    fault_s         = fault_r;
    pc_load_s       = 1'b0;
    pc_load_value_s = pc_s;
    pc_inc_s        = 1'b0;

    if (bus.redirect) begin
      // Redirect flushes both the in-flight word and the output stage.
      infl_v_s    = 1'b0;
      out_valid_s = 1'b0;
      if (bus.redirect_target > PROG_LAST) begin
        state_s = DRAIN;
`ifdef IF_FAULT_EN
        fault_s = 1'b1;
`else
        fault_s = 1'b0;
`endif
      end else begin
        pc_load_s       = 1'b1;
        pc_load_value_s = bus.redirect_target;
        state_s         = FETCH;
      end
    end else begin
      case (state_r)
        FETCH: begin
          if (stall_eff_s) begin
            // The memory overwrites the in-flight word this edge, so rewind
            // pc to re-read it after the stall.
            if (infl_v_r) begin
              pc_load_s       = 1'b1;
              pc_load_value_s = infl_pc_r;
            end else begin
              pc_load_s       = 1'b0;
            end
            infl_v_s = 1'b0;
            state_s  = STALL;
          end else begin
            infl_pc_s   = pc_s;
            infl_v_s    = 1'b1;
            out_instr_s = bus.mem_instruction;
            out_pc_s    = infl_pc_r;
            out_valid_s = infl_v_r;
            if (pc_at_last(pc_s)) begin
              state_s = DRAIN;
            end else begin
              pc_inc_s = 1'b1;
            end
          end
        end
        STALL: begin
          if (bus.stall) begin
            state_s = STALL;
          end else begin
            // Release: the held word is consumed, the replayed address issues.
            out_valid_s = 1'b0;
            infl_pc_s   = pc_s;
            infl_v_s    = 1'b1;
            if (pc_at_last(pc_s)) begin
              state_s = DRAIN;
            end else begin
              pc_inc_s = 1'b1;
              state_s  = FETCH;
            end
          end
        end
        DRAIN: begin
          // pc sits on the last word, so a stalled in-flight word is still
          // what the memory returns; just hold everything.
          if (stall_eff_s) begin
            state_s = DRAIN;
          end else begin
            out_instr_s = bus.mem_instruction;
            out_pc_s    = infl_pc_r;
            out_valid_s = infl_v_r;
            infl_v_s    = 1'b0;
          end
        end
        default: begin
          state_s     = FETCH;
          infl_v_s    = 1'b0;
          out_valid_s = 1'b0;
        end
      endcase
    end
  end

  // Control and output-stage registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= FETCH;
      infl_pc_r   <= {ADDR_W{1'b0}};
      infl_v_r    <= 1'b0;
      out_instr_r <= {INSTR_W{1'b0}};
      out_pc_r    <= {ADDR_W{1'b0}};
      out_valid_r <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      infl_pc_r   <= infl_pc_s;
      infl_v_r    <= infl_v_s;
      out_instr_r <= out_instr_s;
      out_pc_r    <= out_pc_s;
      out_valid_r <= out_valid_s;
      fault_r     <= fault_s;
    end
  end

  assign bus.mem_address = pc_s;
  assign bus.instr_out   = out_instr_r;
  assign bus.instr_pc    = out_pc_r;
  assign bus.instr_valid = out_valid_r;
  assign bus.halted      = (state_r == DRAIN) && !infl_v_r && !out_valid_r;
  assign bus.fetch_fault = fault_r;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

`ifdef IF_FAULT_EN
  localparam bit FAULT_ON = 1'b1;
`else
  localparam bit FAULT_ON = 1'b0;
`endif

  instruction_fetch_if bif ();

  instruction_fetch dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Program image: word(a) = 16'h1000 + a*16'h0451; outside the program 16'hDEAD.
  function automatic logic [15:0] word(input int a);
    logic [15:0] aw;
    aw = 16'(a);
    if (a >= 0 && a <= 8) return 16'h1000 + aw * 16'h0451;
    else return 16'hDEAD;
  endfunction

  // Instruction memory with one-edge registered read.
  always @(posedge clock) bif.mem_instruction <= word(int'(bif.mem_address));

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bif.stall = 1'b0;
    bif.redirect = 1'b0;
    bif.redirect_target = 4'd0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset_run();
    logic [3:0] exp_addr;
    logic       exp_v;
    logic       exp_h;
    do_reset();
    checks++;
    if (bif.mem_address !== 4'd0 || bif.instr_valid !== 1'b0 || bif.instr_pc !== 4'd0) begin
      errors++;
      $display("FAIL reset_state addr=%0d valid=%b pc=%0d required 0/0/0", bif.mem_address, bif.instr_valid, bif.instr_pc);
    end
    checks++;
    if (bif.halted !== 1'b0 || bif.fetch_fault !== 1'b0 || bif.instr_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_flags halted=%b fault=%b out=%h required 0/0/0000", bif.halted, bif.fetch_fault, bif.instr_out);
    end
    for (int n = 1; n <= 12; n++) begin
      tick();
      exp_addr = (n < 8) ? 4'(n) : 4'd8;
      exp_v = (n >= 2) && (n <= 10);
      exp_h = (n >= 11);
      checks++;
      if (bif.mem_address !== exp_addr) begin
        errors++;
        $display("FAIL run_addr edge=%0d got %0d required %0d", n, bif.mem_address, exp_addr);
      end
      checks++;
      if (bif.instr_valid !== exp_v || bif.halted !== exp_h) begin
        errors++;
        $display("FAIL run_flags edge=%0d valid=%b halted=%b required %b/%b", n, bif.instr_valid, bif.halted, exp_v, exp_h);
      end
      if (exp_v) begin
        checks++;
        if (bif.instr_pc !== 4'(n - 2) || bif.instr_out !== word(n - 2)) begin
          errors++;
          $display("FAIL run_word edge=%0d pc=%0d out=%h required %0d/%h", n, bif.instr_pc, bif.instr_out, n - 2, word(n - 2));
        end
      end
    end
  endtask

  task automatic test_stall();
    // Per-edge expectations after the stall is raised (edges 3..8).
    logic [3:0] e_addr [6] = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4};
    logic       e_v    [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] e_pc   [6] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2};
    do_reset();
    repeat (2) tick();
    bif.stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 2) bif.stall = 1'b0;
      checks++;
      if (bif.mem_address !== e_addr[i] || bif.instr_valid !== e_v[i]) begin
        errors++;
        $display("FAIL stall_ctl step=%0d addr=%0d valid=%b required %0d/%b", i, bif.mem_address, bif.instr_valid, e_addr[i], e_v[i]);
      end
      if (e_v[i]) begin
        checks++;
        if (bif.instr_pc !== e_pc[i] || bif.instr_out !== word(int'(e_pc[i]))) begin
          errors++;
          $display("FAIL stall_word step=%0d pc=%0d out=%h required %0d/%h", i, bif.instr_pc, bif.instr_out, e_pc[i], word(int'(e_pc[i])));
        end
      end
    end
    checks++;
    if (word(1) !== 16'h1451) begin
      errors++;
      $display("FAIL stall_image word1=%h required 1451", word(1));
    end
  endtask

  task automatic test_redirect();
    logic [3:0] e_addr [5] = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    logic       e_v    [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] e_pc   [5] = '{4'd0, 4'd0, 4'd4, 4'd5, 4'd6};
    do_reset();
    repeat (8) tick();
    checks++;
    if (bif.instr_pc !== 4'd6 || bif.instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL redir_pre pc=%0d valid=%b required 6/1", bif.instr_pc, bif.instr_valid);
    end
    bif.redirect = 1'b1;
    bif.redirect_target = 4'd4;
    for (int i = 0; i < 5; i++) begin
      tick();
      bif.redirect = 1'b0;
      checks++;
      if (bif.mem_address !== e_addr[i] || bif.instr_valid !== e_v[i]) begin
        errors++;
        $display("FAIL redir_ctl step=%0d addr=%0d valid=%b required %0d/%b", i, bif.mem_address, bif.instr_valid, e_addr[i], e_v[i]);
      end
      if (e_v[i]) begin
        checks++;
        if (bif.instr_pc !== e_pc[i] || bif.instr_out !== word(int'(e_pc[i]))) begin
          errors++;
          $display("FAIL redir_word step=%0d pc=%0d out=%h required %0d/%h", i, bif.instr_pc, bif.instr_out, e_pc[i], word(int'(e_pc[i])));
        end
      end
    end
  endtask

  task automatic test_redirect_stall();
    do_reset();
    repeat (4) tick();
    bif.stall = 1'b1;
    bif.redirect = 1'b1;
    bif.redirect_target = 4'd2;
    tick();
    bif.stall = 1'b0;
    bif.redirect = 1'b0;
    checks++;
    if (bif.mem_address !== 4'd2 || bif.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rs_first addr=%0d valid=%b required 2/0", bif.mem_address, bif.instr_valid);
    end
    tick();
    checks++;
    if (bif.mem_address !== 4'd3 || bif.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rs_second addr=%0d valid=%b required 3/0", bif.mem_address, bif.instr_valid);
    end
    tick();
    checks++;
    if (bif.instr_valid !== 1'b1 || bif.instr_pc !== 4'd2 || bif.instr_out !== word(2)) begin
      errors++;
      $display("FAIL rs_word valid=%b pc=%0d out=%h required 1/2/%h", bif.instr_valid, bif.instr_pc, bif.instr_out, word(2));
    end
  endtask

  task automatic test_drain_redirect();
    do_reset();
    repeat (11) tick();
    checks++;
    if (bif.halted !== 1'b1 || bif.mem_address !== 4'd8) begin
      errors++;
      $display("FAIL drain_halt halted=%b addr=%0d required 1/8", bif.halted, bif.mem_address);
    end
    bif.redirect = 1'b1;
    bif.redirect_target = 4'd0;
    tick();
    bif.redirect = 1'b0;
    checks++;
    if (bif.halted !== 1'b0 || bif.mem_address !== 4'd0 || bif.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_leave halted=%b addr=%0d valid=%b required 0/0/0", bif.halted, bif.mem_address, bif.instr_valid);
    end
    tick();
    tick();
    checks++;
    if (bif.instr_valid !== 1'b1 || bif.instr_pc !== 4'd0 || bif.instr_out !== word(0)) begin
      errors++;
      $display("FAIL drain_resume0 valid=%b pc=%0d out=%h required 1/0/%h", bif.instr_valid, bif.instr_pc, bif.instr_out, word(0));
    end
    tick();
    checks++;
    if (bif.instr_valid !== 1'b1 || bif.instr_pc !== 4'd1 || bif.instr_out !== word(1)) begin
      errors++;
      $display("FAIL drain_resume1 valid=%b pc=%0d out=%h required 1/1/%h", bif.instr_valid, bif.instr_pc, bif.instr_out, word(1));
    end
  endtask

  task automatic test_fault_reset();
    do_reset();
    repeat (4) tick();
    bif.redirect = 1'b1;
    bif.redirect_target = 4'd12;
    tick();
    bif.redirect = 1'b0;
    checks++;
    if (bif.mem_address !== 4'd4 || bif.instr_valid !== 1'b0 || bif.halted !== 1'b1) begin
      errors++;
      $display("FAIL fault_drain addr=%0d valid=%b halted=%b required 4/0/1", bif.mem_address, bif.instr_valid, bif.halted);
    end
    checks++;
    if (bif.fetch_fault !== FAULT_ON) begin
      errors++;
      $display("FAIL fault_flag got %b required %b", bif.fetch_fault, FAULT_ON);
    end
    tick();
    bif.redirect = 1'b1;
    bif.redirect_target = 4'd0;
    tick();
    bif.redirect = 1'b0;
    checks++;
    if (bif.fetch_fault !== FAULT_ON || bif.halted !== 1'b0) begin
      errors++;
      $display("FAIL fault_sticky fault=%b halted=%b required %b/0", bif.fetch_fault, bif.halted, FAULT_ON);
    end
    repeat (2) tick();
    checks++;
    if (bif.instr_valid !== 1'b1 || bif.instr_pc !== 4'd0 || bif.mem_address !== 4'd2) begin
      errors++;
      $display("FAIL fault_restart valid=%b pc=%0d addr=%0d required 1/0/2", bif.instr_valid, bif.instr_pc, bif.mem_address);
    end
    // Pull reset between clock edges; state must clear without a clock.
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bif.instr_valid !== 1'b0 || bif.mem_address !== 4'd0 || bif.fetch_fault !== 1'b0 || bif.instr_out !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset valid=%b addr=%0d fault=%b out=%h required 0/0/0/0000", bif.instr_valid, bif.mem_address, bif.fetch_fault, bif.instr_out);
    end
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    checks++;
    if (bif.mem_address !== 4'd1 || bif.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset addr=%0d valid=%b required 1/0", bif.mem_address, bif.instr_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bif.stall = 1'b0;
    bif.redirect = 1'b0;
    bif.redirect_target = 4'd0;
    test_reset_run();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_drain_redirect();
    test_fault_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch unit that drives the instruction memory's 4-bit read address and collects the returned 16-bit instruction words for decode. It owns the program counter and accounts for the memory's one-edge registered read. It presents instructions to decode with a valid/stall handshake, handles branch/jump redirects, and never drives an address past the last program word. Sits between the instruction memory and the control/decode stage of the 16-bit processor.

## Interface
- ADDR_W, 4, instruction address width
- INSTR_W, 16, instruction word width
- PROG_LAST, 4'd8, highest legal program address
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- mem_address  out  ADDR_W  read address to instruction memory (= pc register)
- mem_instruction  in  INSTR_W  memory output; holds word for address sampled at previous edge
- stall  in  1  decode does not consume instr_out this cycle
- redirect  in  1  branch/jump taken
- redirect_target  in  ADDR_W  new pc on redirect
- instr_out  out  INSTR_W  registered instruction to decode
- instr_pc  out  ADDR_W  address of instr_out
- instr_valid  out  1  instr_out is meaningful
- halted  out  1  program drained, nothing in flight
- fetch_fault  out  1  sticky out-of-range redirect flag (see Configuration)

## Operation
- Registers: pc, infl_pc/infl_v (address issued last edge), output stage (instr_out/instr_pc/instr_valid), state.
- States: FETCH, STALL, DRAIN. Reset: state FETCH, pc 0, infl_v 0, all outputs 0.
- FETCH, no stall: each edge infl_pc<=pc, infl_v<=1; output stage <= {mem_instruction, infl_pc, infl_v}. pc<=pc+1 if pc<PROG_LAST; if issuing pc==PROG_LAST, pc holds, state->DRAIN.
- Stall (stall=1 with instr_valid=1): output stage holds; pc<=infl_pc if infl_v (replay the word the memory is about to overwrite); infl_v<=0; state->STALL. Stall with instr_valid=0 is ignored.
- STALL: pc, outputs held while stall=1. First edge with stall=0: instr_valid<=0 (word consumed), infl_pc<=pc, infl_v<=1, pc advances, state->FETCH (DRAIN if pc==PROG_LAST). Exactly one bubble after release.
- Redirect (any state): pc<=redirect_target, infl_v<=0, instr_valid<=0, state->FETCH. Redirect beats stall in the same cycle.
- DRAIN: no new issue; mem_address held at PROG_LAST; in-flight word and output stage drain normally (stall still honoured). halted=1 when state DRAIN, infl_v=0 and instr_valid=0. Redirect leaves DRAIN, halted drops next edge.
- pc arithmetic is ADDR_W wide; never wraps, because increment stops at PROG_LAST.

## Timing
- Issue-to-output latency: 2 edges (address sampled at edge k, word registered at edge k+1, valid after k+1).
- Back-to-back throughput: 1 word/cycle without stall.
- Redirect: first redirected word valid 2 edges after the redirect edge; 2-cycle bubble.
- halted asserts combinationally from registers; 2 edges after last issue if unstalled.
- Reset mid-operation: all state cleared immediately, regardless of clock; first address 0 issued at first edge after release.

## Configuration
- IF_FAULT_EN defined: redirect_target>PROG_LAST sets fetch_fault (sticky until reset), pc unchanged, flushes as a redirect, state->DRAIN.
- Undefined: same DRAIN/flush behaviour, fetch_fault tied 0. Either way mem_address never exceeds PROG_LAST.

## Structure
- fetch_pkg: ADDR_W, INSTR_W, PROG_LAST defaults, state enum {FETCH, STALL, DRAIN}.
- One sub-module: pc_counter (pc register, saturating increment, load for redirect/replay).

## Test plan
- Reset release, stall=0: mem_address 0..8 then holds 8; instr_pc 0..8 valid from second edge, words match memory; halted=1 two edges after address 8 issued; mem_address never >8.
- stall high 3 cycles while instr_pc=0: instr_out held, mem_address rewinds to 1; after release one invalid cycle, then instr_pc=1, word 16'h1451.
- redirect to 4 while instr_pc=6: instr_valid low two cycles, next valid instr_pc=4, then 5, 6.
- redirect to 2 and stall in same cycle: redirect wins, next valid instr_pc=2.
- In DRAIN with halted=1, redirect to 0: halted drops, instr_pc 0,1,... resumes.
- IF_FAULT_EN, redirect to 12: fetch_fault=1 sticky, DRAIN, halted=1, mem_address ≤8; reset_n low mid-stream clears everything asynchronously.
